// File: rtl/writeback_arbiter.sv
// writeback_arbiter
// Final pipeline stage: merges single-cycle ALU results and buffered load
// results into one register-file write per cycle, and tracks outstanding
// writes per architectural register so decode can stall on RAW hazards.
//
// No sequencing FSM here: the only state is the load FIFO, the writeback
// register and the pending scoreboard, all updated on enabled edges.
//
// Arbitration priority (evaluated every cycle):
//   source  | condition
//   LQ head | load FIFO full (guarantees load progress)
//   ALU     | FIFO not full and alu_valid
//   LQ head | FIFO not full, no ALU result, FIFO non-empty
//   none    | otherwise

module writeback_arbiter #(
    parameter int LQ_DEPTH = 2,
    parameter int DATA_W   = 16,
    parameter int REG_AW   = 3
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   clock_enable,

    input  logic                   issue_valid,
    input  logic [REG_AW-1:0]      issue_dest,

    input  logic                   alu_valid,
    output logic                   alu_ready,
    input  logic [REG_AW-1:0]      alu_dest,
    input  logic [DATA_W-1:0]      alu_data,

    input  logic                   mem_valid,
    output logic                   mem_ready,
    input  logic [REG_AW-1:0]      mem_dest,
    input  logic [DATA_W-1:0]      mem_data,

    output logic                   reg_write_en,
    output logic [REG_AW-1:0]      reg_write_dest,
    output logic [DATA_W-1:0]      reg_write_data,

    output logic [2**REG_AW-1:0]   pending,
    output logic                   busy
);

    localparam int NREG  = 2**REG_AW;
    localparam int PTR_W = (LQ_DEPTH > 1) ? $clog2(LQ_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] LQ_FULL_CNT = CNT_W'(LQ_DEPTH);

    typedef enum logic [1:0] {
        SRC_NONE = 2'd0,
        SRC_ALU  = 2'd1,
        SRC_LQ   = 2'd2
    } src_e;

    // Load FIFO storage and bookkeeping
    logic [REG_AW-1:0]  lq_dest_q [LQ_DEPTH];
    logic [DATA_W-1:0]  lq_data_q [LQ_DEPTH];
    logic [PTR_W-1:0]   lq_wr_ptr_q;
    logic [PTR_W-1:0]   lq_rd_ptr_q;
    logic [CNT_W-1:0]   lq_count_q;
    logic               lq_empty;
    logic               lq_full;
    logic               lq_push;
    logic               lq_pop;

    // Writeback register and scoreboard
    logic               wb_valid_q;
    logic [REG_AW-1:0]  wb_dest_q;
    logic [DATA_W-1:0]  wb_data_q;
    logic [NREG-1:0]    pending_q;
    logic [NREG-1:0]    set_mask;
    logic [NREG-1:0]    clr_mask;

    src_e               src;

    assign lq_empty = (lq_count_q == '0);
    assign lq_full  = (lq_count_q == LQ_FULL_CNT);

    // Ready is held low during reset so no producer believes a transfer
    // completed on an edge whose effect reset discards.
    assign mem_ready = reset_n & clock_enable & ~lq_full;
    assign alu_ready = reset_n & clock_enable & ~lq_full;

    assign lq_push = mem_valid & mem_ready;
    assign lq_pop  = reset_n & clock_enable & (src == SRC_LQ);

    assign reg_write_en   = wb_valid_q & clock_enable;
    assign reg_write_dest = wb_dest_q;
    assign reg_write_data = wb_data_q;
    assign pending        = pending_q;
    assign busy           = ~lq_empty | wb_valid_q | (|pending_q);

    // Pick this cycle's writeback source; a full FIFO pre-empts the ALU
    always_comb begin
        src = SRC_NONE;
        if (lq_full) begin
            src = SRC_LQ;
        end else if (alu_valid) begin
            src = SRC_ALU;
        end else if (!lq_empty) begin
            src = SRC_LQ;
        end
    end

    // Load FIFO data entries; contents need no reset since count gates them
    always_ff @(posedge clk) begin
        if (lq_push) begin
            lq_dest_q[lq_wr_ptr_q] <= mem_dest;
            lq_data_q[lq_wr_ptr_q] <= mem_data;
        end
    end

    // Load FIFO pointers and occupancy; pointers wrap naturally (power-of-two depth)
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            lq_wr_ptr_q <= '0;
            lq_rd_ptr_q <= '0;
            lq_count_q  <= '0;
        end else if (clock_enable) begin
            if (lq_push) begin
                lq_wr_ptr_q <= lq_wr_ptr_q + PTR_W'(1);
            end
            if (lq_pop) begin
                lq_rd_ptr_q <= lq_rd_ptr_q + PTR_W'(1);
            end
            case ({lq_push, lq_pop})
                2'b10:   lq_count_q <= lq_count_q + CNT_W'(1);
                2'b01:   lq_count_q <= lq_count_q - CNT_W'(1);
                default: lq_count_q <= lq_count_q;
            endcase
        end
    end

    // Writeback register: capture the winner, or drop valid and hold dest/data
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wb_valid_q <= 1'b0;
            wb_dest_q  <= '0;
            wb_data_q  <= '0;
        end else if (clock_enable) begin
            case (src)
                SRC_ALU: begin
                    wb_valid_q <= 1'b1;
                    wb_dest_q  <= alu_dest;
                    wb_data_q  <= alu_data;
                end
                SRC_LQ: begin
                    wb_valid_q <= 1'b1;
                    wb_dest_q  <= lq_dest_q[lq_rd_ptr_q];
                    wb_data_q  <= lq_data_q[lq_rd_ptr_q];
                end
                default: begin
                    wb_valid_q <= 1'b0;
                end
            endcase
        end
    end

    // Scoreboard set/clear masks for this cycle
    always_comb begin
        set_mask = '0;
        clr_mask = '0;
        if (issue_valid) begin
            set_mask[issue_dest] = 1'b1;
        end
        if (reg_write_en) begin
            clr_mask[reg_write_dest] = 1'b1;
        end
    end

    // Scoreboard update; set is applied after clear so a newer issue survives
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            pending_q <= '0;
        end else if (clock_enable) begin
            pending_q <= (pending_q & ~clr_mask) | set_mask;
        end
    end

endmodule

// File: tb/tb_writeback_arbiter.sv
// Directed bench for writeback_arbiter: reset, ALU/load contention,
// stall, scoreboard set/clear collision, mid-operation reset, FIFO wrap.

module tb_writeback_arbiter;

    logic        clk;
    logic        reset_n;
    logic        clock_enable;
    logic        issue_valid;
    logic [2:0]  issue_dest;
    logic        alu_valid;
    logic        alu_ready;
    logic [2:0]  alu_dest;
    logic [15:0] alu_data;
    logic        mem_valid;
    logic        mem_ready;
    logic [2:0]  mem_dest;
    logic [15:0] mem_data;
    logic        reg_write_en;
    logic [2:0]  reg_write_dest;
    logic [15:0] reg_write_data;
    logic [7:0]  pending;
    logic        busy;

    int n_checks = 0;
    int n_pass   = 0;

    // Observed register-file writes as {dest, data}
    logic [18:0] wr_log [$];

    writeback_arbiter #(
        .LQ_DEPTH (2),
        .DATA_W   (16),
        .REG_AW   (3)
    ) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .clock_enable   (clock_enable),
        .issue_valid    (issue_valid),
        .issue_dest     (issue_dest),
        .alu_valid      (alu_valid),
        .alu_ready      (alu_ready),
        .alu_dest       (alu_dest),
        .alu_data       (alu_data),
        .mem_valid      (mem_valid),
        .mem_ready      (mem_ready),
        .mem_dest       (mem_dest),
        .mem_data       (mem_data),
        .reg_write_en   (reg_write_en),
        .reg_write_dest (reg_write_dest),
        .reg_write_data (reg_write_data),
        .pending        (pending),
        .busy           (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Record each cycle in which the register file is written
    always @(negedge clk) begin
        if (reg_write_en === 1'b1) begin
            wr_log.push_back({reg_write_dest, reg_write_data});
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle(input string name);
        int guard = 0;
        while (busy !== 1'b0 && guard < 40) begin
            step();
            guard++;
        end
        n_checks++;
        if (busy !== 1'b0) $display("FAIL %s_idle_timeout: busy=%b required 0", name, busy);
        else n_pass++;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        alu_valid = 1'b1; alu_dest = 3'd3; alu_data = 16'hBEEF;
        for (int c = 0; c < 2; c++) begin
            step();
            n_checks++;
            if (reg_write_en !== 1'b0) $display("FAIL reset_wen: got %b required 0", reg_write_en);
            else n_pass++;
            n_checks++;
            if (pending !== 8'h00) $display("FAIL reset_pending: got %h required 00", pending);
            else n_pass++;
            n_checks++;
            if (alu_ready !== 1'b0) $display("FAIL reset_alu_ready: got %b required 0", alu_ready);
            else n_pass++;
            n_checks++;
            if (busy !== 1'b0) $display("FAIL reset_busy: got %b required 0", busy);
            else n_pass++;
        end
        reset_n = 1'b1;
        #1;
        n_checks++;
        if (alu_ready !== 1'b1) $display("FAIL release_alu_ready: got %b required 1", alu_ready);
        else n_pass++;
        step();
        alu_valid = 1'b0;
        #1;
        n_checks++;
        if ({reg_write_en, reg_write_dest, reg_write_data} !== {1'b1, 3'd3, 16'hBEEF})
            $display("FAIL first_alu_write: got en=%b dest=%0d data=%h required en=1 dest=3 data=beef",
                     reg_write_en, reg_write_dest, reg_write_data);
        else n_pass++;
        step();
        n_checks++;
        if (reg_write_en !== 1'b0 || busy !== 1'b0)
            $display("FAIL after_first_write: got en=%b busy=%b required 0 0", reg_write_en, busy);
        else n_pass++;
    endtask

    task automatic test_contention();
        logic [18:0] exp_w [8];
        int n  = 1;
        int am = 0;
        logic acc_a, acc_m;
        exp_w = '{{3'd1, 16'h0001}, {3'd1, 16'h0002}, {3'd5, 16'hAAAA}, {3'd1, 16'h0003},
                  {3'd1, 16'h0004}, {3'd1, 16'h0005}, {3'd1, 16'h0006}, {3'd5, 16'hBBBB}};
        wr_log.delete();
        for (int cyc = 0; cyc < 12; cyc++) begin
            alu_valid = (n <= 6);
            alu_dest  = 3'd1;
            alu_data  = 16'(n);
            mem_valid = (am < 2);
            mem_dest  = 3'd5;
            mem_data  = (am == 0) ? 16'hAAAA : 16'hBBBB;
            #1;
            if (cyc == 2) begin
                n_checks++;
                if (alu_ready !== 1'b0 || mem_ready !== 1'b0)
                    $display("FAIL full_ready: got alu_ready=%b mem_ready=%b required 0 0", alu_ready, mem_ready);
                else n_pass++;
            end
            acc_a = alu_valid & alu_ready;
            acc_m = mem_valid & mem_ready;
            step();
            if (acc_a) n++;
            if (acc_m) am++;
            if (cyc == 2) begin
                n_checks++;
                if ({reg_write_en, reg_write_dest, reg_write_data} !== {1'b1, 3'd5, 16'hAAAA})
                    $display("FAIL full_head_write: got en=%b dest=%0d data=%h required en=1 dest=5 data=aaaa",
                             reg_write_en, reg_write_dest, reg_write_data);
                else n_pass++;
            end
        end
        alu_valid = 1'b0;
        mem_valid = 1'b0;
        wait_idle("contention");
        n_checks++;
        if (wr_log.size() != 8) $display("FAIL contention_count: got %0d writes required 8", wr_log.size());
        else n_pass++;
        for (int k = 0; k < 8; k++) begin
            if (k < wr_log.size()) begin
                n_checks++;
                if (wr_log[k] !== exp_w[k])
                    $display("FAIL contention_order[%0d]: got dest=%0d data=%h required dest=%0d data=%h",
                             k, wr_log[k][18:16], wr_log[k][15:0], exp_w[k][18:16], exp_w[k][15:0]);
                else n_pass++;
            end
        end
    endtask

    task automatic test_stall();
        wr_log.delete();
        alu_valid = 1'b1; alu_dest = 3'd2; alu_data = 16'h1234;
        step();
        alu_valid    = 1'b0;
        clock_enable = 1'b0;
        issue_valid  = 1'b1; issue_dest = 3'd6;
        mem_valid    = 1'b1; mem_dest = 3'd3; mem_data = 16'h3333;
        for (int c = 0; c < 3; c++) begin
            #1;
            n_checks++;
            if (reg_write_en !== 1'b0 || mem_ready !== 1'b0 || alu_ready !== 1'b0)
                $display("FAIL stall_outputs[%0d]: got wen=%b mem_ready=%b alu_ready=%b required 0 0 0",
                         c, reg_write_en, mem_ready, alu_ready);
            else n_pass++;
            n_checks++;
            if (pending !== 8'h00 || busy !== 1'b1)
                $display("FAIL stall_state[%0d]: got pending=%h busy=%b required 00 1", c, pending, busy);
            else n_pass++;
            step();
        end
        issue_valid  = 1'b0;
        mem_valid    = 1'b0;
        clock_enable = 1'b1;
        #1;
        n_checks++;
        if ({reg_write_en, reg_write_dest, reg_write_data} !== {1'b1, 3'd2, 16'h1234})
            $display("FAIL stall_release_write: got en=%b dest=%0d data=%h required en=1 dest=2 data=1234",
                     reg_write_en, reg_write_dest, reg_write_data);
        else n_pass++;
        step();
        n_checks++;
        if (reg_write_en !== 1'b0 || pending !== 8'h00)
            $display("FAIL stall_after: got wen=%b pending=%h required 0 00", reg_write_en, pending);
        else n_pass++;
        wait_idle("stall");
        n_checks++;
        if (wr_log.size() != 1 || wr_log[0] !== {3'd2, 16'h1234})
            $display("FAIL stall_single_write: got %0d writes required exactly one 2/1234", wr_log.size());
        else n_pass++;
    endtask

    task automatic test_scoreboard();
        issue_valid = 1'b1; issue_dest = 3'd4;
        step();
        issue_valid = 1'b0;
        #1;
        n_checks++;
        if (pending !== 8'h10 || busy !== 1'b1)
            $display("FAIL sb_issue: got pending=%h busy=%b required 10 1", pending, busy);
        else n_pass++;
        alu_valid = 1'b1; alu_dest = 3'd4; alu_data = 16'h4444;
        step();
        alu_valid = 1'b0;
        issue_valid = 1'b1; issue_dest = 3'd4;
        #1;
        n_checks++;
        if (reg_write_en !== 1'b1 || reg_write_dest !== 3'd4)
            $display("FAIL sb_collide_write: got wen=%b dest=%0d required 1 4", reg_write_en, reg_write_dest);
        else n_pass++;
        step();
        issue_valid = 1'b0;
        #1;
        n_checks++;
        if (pending !== 8'h10) $display("FAIL sb_set_wins: got pending=%h required 10", pending);
        else n_pass++;
        alu_valid = 1'b1; alu_dest = 3'd4; alu_data = 16'h5555;
        step();
        alu_valid = 1'b0;
        step();
        n_checks++;
        if (pending !== 8'h00 || busy !== 1'b0)
            $display("FAIL sb_clear: got pending=%h busy=%b required 00 0", pending, busy);
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        alu_valid = 1'b1; alu_dest = 3'd7; alu_data = 16'h0777;
        mem_valid = 1'b1; mem_dest = 3'd2; mem_data = 16'h2222;
        issue_valid = 1'b1; issue_dest = 3'd2;
        step();
        mem_dest = 3'd5; mem_data = 16'h5555;
        issue_dest = 3'd5;
        step();
        alu_valid = 1'b0; mem_valid = 1'b0; issue_valid = 1'b0;
        #1;
        n_checks++;
        if (mem_ready !== 1'b0 || pending !== 8'h24)
            $display("FAIL mid_setup: got mem_ready=%b pending=%h required 0 24", mem_ready, pending);
        else n_pass++;
        reset_n = 1'b0;
        step();
        reset_n = 1'b1;
        wr_log.delete();
        #1;
        n_checks++;
        if (pending !== 8'h00 || busy !== 1'b0 || reg_write_en !== 1'b0 || mem_ready !== 1'b1)
            $display("FAIL mid_reset_state: got pending=%h busy=%b wen=%b mem_ready=%b required 00 0 0 1",
                     pending, busy, reg_write_en, mem_ready);
        else n_pass++;
        for (int c = 0; c < 5; c++) step();
        n_checks++;
        if (wr_log.size() != 0) $display("FAIL mid_no_stale_write: got %0d writes required 0", wr_log.size());
        else n_pass++;
    endtask

    task automatic test_wrap();
        int i = 0;
        int guard = 0;
        logic acc;
        wr_log.delete();
        while (i < 5 && guard < 50) begin
            mem_valid = 1'b1;
            mem_dest  = 3'(i);
            mem_data  = 16'(32'h10 + i);
            #1;
            acc = mem_ready;
            step();
            guard++;
            if (acc) begin
                if (i == 0) begin
                    n_checks++;
                    if (reg_write_en !== 1'b0) $display("FAIL wrap_latency_early: got wen=%b required 0", reg_write_en);
                    else n_pass++;
                end
                if (i == 1) begin
                    n_checks++;
                    if ({reg_write_en, reg_write_dest, reg_write_data} !== {1'b1, 3'd0, 16'h0010})
                        $display("FAIL wrap_latency: got en=%b dest=%0d data=%h required en=1 dest=0 data=0010",
                                 reg_write_en, reg_write_dest, reg_write_data);
                    else n_pass++;
                end
                i++;
            end
        end
        mem_valid = 1'b0;
        n_checks++;
        if (i != 5) $display("FAIL wrap_push_timeout: got %0d pushes required 5", i);
        else n_pass++;
        wait_idle("wrap");
        n_checks++;
        if (wr_log.size() != 5) $display("FAIL wrap_count: got %0d writes required 5", wr_log.size());
        else n_pass++;
        for (int k = 0; k < 5; k++) begin
            if (k < wr_log.size()) begin
                n_checks++;
                if (wr_log[k] !== {3'(k), 16'(32'h10 + k)})
                    $display("FAIL wrap_order[%0d]: got dest=%0d data=%h required dest=%0d data=%h",
                             k, wr_log[k][18:16], wr_log[k][15:0], k, 32'h10 + k);
                else n_pass++;
            end
        end
    endtask

    initial begin
        reset_n      = 1'b0;
        clock_enable = 1'b1;
        issue_valid  = 1'b0;
        issue_dest   = 3'd0;
        alu_valid    = 1'b0;
        alu_dest     = 3'd0;
        alu_data     = 16'h0000;
        mem_valid    = 1'b0;
        mem_dest     = 3'd0;
        mem_data     = 16'h0000;

        test_reset();
        test_contention();
        test_stall();
        test_scoreboard();
        test_reset_mid();
        test_wrap();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
